// File: rtl/pd_block_pio_pkg.sv
// Shared definitions for the PIO-style input blocks: register word
// addresses, edge-capture mode encodings and the debounce counter width.
package pd_block_pio_pkg;

   // Avalon-MM word addresses of the register file
   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_DIR  = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   // Which debounced transitions are latched into EDGE_CAPTURE
   typedef enum logic [1:0] {
      EDGE_RISE = 2'd0,
      EDGE_FALL = 2'd1,
      EDGE_ANY  = 2'd2
   } edge_type_e;

   // Width of the per-bit stability counter
   localparam int DEB_CNT_W = 16;

   // True when a debounced transition qualifies for capture in the given mode
   function automatic logic edge_qualifies(input int edge_type,
                                           input logic rise,
                                           input logic fall);
      logic q;
      q = 1'b0;
      if (edge_type == int'(EDGE_RISE))      q = rise;
      else if (edge_type == int'(EDGE_FALL)) q = fall;
      else                                   q = rise | fall;
      return q;
   endfunction

endpackage

// File: rtl/pd_block_debounce_bit.sv
// One input bit: two-flop synchronizer, stability counter and debounced
// flop. rise/fall pulse for one cycle, combinationally, in the cycle whose
// closing edge loads the new debounced value.
module pd_block_debounce_bit
   import pd_block_pio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic deb,
   output logic rise,
   output logic fall
);

   localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                 sync1;
   logic                 sync2;
   logic [DEB_CNT_W-1:0] cnt;
   logic                 differ;
   logic                 accept;

   assign differ = sync2 ^ deb;
   assign accept = differ && (cnt == CNT_LAST);
   assign rise   = accept & sync2;
   assign fall   = accept & ~sync2;

   // Bring the asynchronous pin into the clk domain
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
      end
   end

   // Count consecutive cycles the synchronized input disagrees with deb
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 cnt <= '0;
      else if (!differ || accept) cnt <= '0;
      else                       cnt <= cnt + DEB_CNT_W'(1);
   end

   // Accept the new level once it has been stable long enough
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       deb <= 1'b0;
      else if (accept) deb <= sync2;
   end

endmodule

// File: rtl/pd_block_sw_capture.sv
// Debounced switch capture peripheral with an Avalon-MM slave port:
// DATA / DIRECTION / IRQ_MASK / EDGE_CAPTURE registers and a level irq.
//
// Bus handshake: a write is accepted on the rising clk edge where
// chipselect=1 and write_n=0; there is no wait state and no back-pressure.
// A read is purely combinational from address and has no side effects.
module pd_block_sw_capture
   import pd_block_pio_pkg::*;
#(
   parameter int WIDTH           = 10,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int EDGE_TYPE       = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] deb_vec;
   logic [WIDTH-1:0] rise_vec;
   logic [WIDTH-1:0] fall_vec;
   logic [WIDTH-1:0] edge_set;
   logic [WIDTH-1:0] edge_clr;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] rd_field;
   logic             wr_en;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         pd_block_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_deb (
            .clk   (clk),
            .reset (reset),
            .din   (in_port[gi]),
            .deb   (deb_vec[gi]),
            .rise  (rise_vec[gi]),
            .fall  (fall_vec[gi])
         );
      end
      if (WIDTH < 32) begin : g_wd_hi
         // Upper write-data bits have no register behind them
         logic unused_wd_hi;
         assign unused_wd_hi = ^writedata[31:WIDTH];
      end
   endgenerate

   assign wr_en    = chipselect & ~write_n;
   assign edge_clr = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

   // Select which debounced transitions latch into EDGE_CAPTURE
   always_comb begin
      edge_set = '0;
      for (int i = 0; i < WIDTH; i++) begin
         edge_set[i] = edge_qualifies(EDGE_TYPE, rise_vec[i], fall_vec[i]);
      end
   end

   // IRQ_MASK register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                               irq_mask <= '0;
      else if (wr_en && address == ADDR_MASK) irq_mask <= writedata[WIDTH-1:0];
   end

   // EDGE_CAPTURE: write-1-to-clear, a new edge in the same cycle wins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) edge_cap <= '0;
      else       edge_cap <= (edge_cap & ~edge_clr) | edge_set;
   end

   // Zero-wait-state read mux; DIRECTION always reads as all inputs
   always_comb begin
      rd_field = '0;
      case (address)
         ADDR_DATA: rd_field = deb_vec;
         ADDR_DIR:  rd_field = '0;
         ADDR_MASK: rd_field = irq_mask;
         ADDR_EDGE: rd_field = edge_cap;
         default:   rd_field = '0;
      endcase
      readdata = 32'(rd_field);
   end

   assign irq = |(edge_cap & irq_mask);

endmodule

// File: doc/pd_block_sw_capture.md
PD_BLOCK_SW_CAPTURE -- requirements
Module: pd_block_sw_capture

Interface
REQ-001 Parameter WIDTH, default 10, number of input bits (DE10-Lite slide switches).
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, stable cycles required before an input change is accepted; legal range 1..65535.
REQ-003 Parameter EDGE_TYPE, default 2, capture mode: 0 rising, 1 falling, 2 any edge.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  system clock, all logic on rising edge.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 address  input  2  Avalon-MM slave word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  read data, zero-extended.
REQ-012 in_port  input  WIDTH  raw asynchronous external inputs.
REQ-013 irq  output  1  level interrupt, active-high.

Function
REQ-014 Register map: 0 DATA (RO, debounced value), 1 DIRECTION (reads 0, writes ignored), 2 IRQ_MASK (RW, WIDTH bits), 3 EDGE_CAPTURE (read; write-1-to-clear).
REQ-015 Read is zero-wait-state, combinational: readdata reflects the addressed register in the same cycle; bits above WIDTH read 0; reads have no side effects.
REQ-016 Write occurs on a clock edge when chipselect=1 and write_n=0; writedata[WIDTH-1:0] used, upper bits ignored.
REQ-017 Each in_port bit passes through a two-flop synchronizer (sync1, sync2).
REQ-018 Per bit: a 16-bit stability counter increments while sync2 != deb, and clears to 0 whenever sync2 == deb.
REQ-019 Per bit: when sync2 != deb and counter == DEBOUNCE_CYCLES-1, deb loads sync2 and the counter clears on the same edge.
REQ-020 Latency: an in_port change held stable from before edge N appears in DATA after edge N+DEBOUNCE_CYCLES+1 (DEBOUNCE_CYCLES+2 edges total).
REQ-021 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles does not change deb or EDGE_CAPTURE.
REQ-022 EDGE_CAPTURE bit sets on the same edge its deb bit updates, if the update matches EDGE_TYPE (0: 0->1, 1: 1->0, 2: either).
REQ-023 EDGE_CAPTURE bits stay set until cleared by a write of 1 to that bit at address 3; writing 0 leaves the bit unchanged.
REQ-024 Simultaneous clear and new qualifying edge on the same bit in the same cycle: bit remains 1 (set wins).
REQ-025 irq = OR over (EDGE_CAPTURE & IRQ_MASK), combinational from registers; no additional latency.
REQ-026 Changing IRQ_MASK does not alter EDGE_CAPTURE; unmasking a set bit asserts irq on the following cycle.

Reset
REQ-027 On reset assertion, asynchronously: sync1, sync2, deb, counters, IRQ_MASK, EDGE_CAPTURE = 0; irq = 0; readdata = 0.
REQ-028 Reset mid-debounce discards the pending change; an input held high through reset release is re-qualified and yields a rising edge DEBOUNCE_CYCLES+2 edges after release.
REQ-029 Reset deassertion is synchronized externally; no register updates while reset is high.

Structure
REQ-030 A shared package pd_block_pio_pkg holds register address constants (ADDR_DATA=0, ADDR_DIR=1, ADDR_MASK=2, ADDR_EDGE=3) and EDGE_TYPE encodings (EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2).
REQ-031 One sub-module, pd_block_debounce_bit (synchronizer, counter, deb flop, rise/fall strobes), instantiated WIDTH times via generate.
REQ-032 Top level holds the register file, edge-capture logic, read mux and irq reduction; target 150-300 RTL lines total.

Verification (bench uses WIDTH=10, DEBOUNCE_CYCLES=4, EDGE_TYPE=2)
REQ-033 Reset release, then read addr 0,1,2,3 -> all return 0x00000000, irq=0.
REQ-034 in_port 0x000->0x005 held -> DATA reads 0x005 exactly 6 edges later, not at 5; EDGE_CAPTURE=0x005 on the same edge; irq=0 with mask 0.
REQ-035 in_port bit3 pulsed high for 3 cycles -> DATA and EDGE_CAPTURE unchanged (0x000).
REQ-036 Write IRQ_MASK=0x001 with EDGE_CAPTURE=0x005 -> irq=1 next cycle; write 0x001 to addr 3 -> EDGE_CAPTURE=0x004, irq=0.
REQ-037 Write 0x3FF to addr 3 on the same edge bit0 debounces 1->0 -> EDGE_CAPTURE bit0 stays 1, others clear.
REQ-038 Assert reset 2 cycles into a debounce of in_port=0x200 -> all registers 0; after release, DATA=0x200 after 6 edges, EDGE_CAPTURE=0x200.
